// File: rtl/asap_pkg.sv
// Shared types for the ASAP-1 control sequencer: opcodes, sequencer states
// and the packed control word that carries one bit per bus strobe.
package asap_pkg;

  localparam int OP_BITS = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_EXEC0  = 3'd3,
    ST_EXEC1  = 3'd4,
    ST_EXEC2  = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef struct packed {
    logic pc_oe;
    logic pc_ie;
    logic pc_inc;
    logic mar_ie;
    logic ram_oe;
    logic ram_ie;
    logic ir_ie;
    logic ir_oe;
    logic a_ie;
    logic a_oe;
    logic b_ie;
    logic alu_oe;
    logic alu_sub;
    logic flags_ie;
    logic out_ie;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NONE = '0;

endpackage

// File: rtl/asap_microcode_rom.sv
// Combinational microcode: maps (state, opcode, flags) to the control word
// for that T-state and whether it is the final step of the instruction.
module asap_microcode_rom
  import asap_pkg::*;
(
  input  state_t     state,
  input  opcode_t    op,
  input  logic       carry,
  input  logic       zero,
  output ctrl_word_t cw,
  output logic       last_step
);

  // Decode one T-state; undefined opcodes fall through to the NOP behaviour.
  always_comb begin
    cw        = CW_NONE;
    last_step = 1'b0;
    case (state)
      ST_FETCH0: begin
        cw.pc_oe  = 1'b1;
        cw.mar_ie = 1'b1;
      end
      ST_FETCH1: begin
        cw.ram_oe = 1'b1;
        cw.ir_ie  = 1'b1;
        cw.pc_inc = 1'b1;
      end
      ST_EXEC0: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw.ir_oe  = 1'b1;
            cw.mar_ie = 1'b1;
          end
          OP_LDI: begin
            cw.ir_oe  = 1'b1;
            cw.a_ie   = 1'b1;
            last_step = 1'b1;
          end
          OP_JMP: begin
            cw.ir_oe  = 1'b1;
            cw.pc_ie  = 1'b1;
            last_step = 1'b1;
          end
          OP_JC: begin
            // Operand is still driven when not taken; nobody captures it.
            cw.ir_oe  = 1'b1;
            cw.pc_ie  = carry;
            last_step = 1'b1;
          end
          OP_JZ: begin
            cw.ir_oe  = 1'b1;
            cw.pc_ie  = zero;
            last_step = 1'b1;
          end
          OP_OUT: begin
            cw.a_oe   = 1'b1;
            cw.out_ie = 1'b1;
            last_step = 1'b1;
          end
          default: begin
            // NOP, HLT and undefined opcodes: empty step that ends the instruction.
            last_step = 1'b1;
          end
        endcase
      end
      ST_EXEC1: begin
        case (op)
          OP_LDA: begin
            cw.ram_oe = 1'b1;
            cw.a_ie   = 1'b1;
            last_step = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw.ram_oe = 1'b1;
            cw.b_ie   = 1'b1;
          end
          OP_STA: begin
            cw.a_oe   = 1'b1;
            cw.ram_ie = 1'b1;
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      ST_EXEC2: begin
        if (op == OP_ADD || op == OP_SUB) begin
          cw.alu_oe   = 1'b1;
          cw.a_ie     = 1'b1;
          cw.flags_ie = 1'b1;
          cw.alu_sub  = (op == OP_SUB);
        end
        last_step = 1'b1;
      end
      default: begin
        cw        = CW_NONE;
        last_step = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/asap_control_sequencer.sv
// ASAP-1 control sequencer: state register, run/freeze handling and the
// registered control word. Outputs change on posedge so they are settled
// before the bus registers capture on the following negedge.
module asap_control_sequencer
  import asap_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [OPW-1:0] opcode,
  input  logic           carry_flag,
  input  logic           zero_flag,
  output logic           pc_oe,
  output logic           pc_ie,
  output logic           pc_inc,
  output logic           mar_ie,
  output logic           ram_oe,
  output logic           ram_ie,
  output logic           ir_ie,
  output logic           ir_oe,
  output logic           a_ie,
  output logic           a_oe,
  output logic           b_ie,
  output logic           alu_oe,
  output logic           alu_sub,
  output logic           flags_ie,
  output logic           out_ie,
  output logic           halted,
  output logic           instr_done
);

  state_t     state_reg, state_next, issue_state, end_state;
  opcode_t    op_reg, rom_op;
  ctrl_word_t cw_reg, rom_cw;
  logic       rom_last;
  logic       last_reg;     // current state was issued as the final step
  logic       frozen_reg;   // previous posedge saw enable=0
  logic       halted_reg, done_reg;
  logic       resume;

  // After a freeze the held state's word is issued again before advancing.
  // IDLE has nothing to re-issue, so it starts straight away.
  assign resume = frozen_reg && (state_reg != ST_IDLE);

  // Next-state decode; end-of-instruction is known from the registered last step.
  always_comb begin
    end_state  = (op_reg == OP_HLT) ? ST_HALT : ST_FETCH0;
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   state_next = ST_FETCH0;
      ST_FETCH0: state_next = ST_FETCH1;
      ST_FETCH1: state_next = ST_EXEC0;
      ST_EXEC0:  state_next = last_reg ? end_state : ST_EXEC1;
      ST_EXEC1:  state_next = last_reg ? end_state : ST_EXEC2;
      ST_EXEC2:  state_next = end_state;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode: pick the state whose word goes out at the next posedge.
  // The opcode input is only consulted on the edge that leaves FETCH1.
  always_comb begin
    issue_state = resume ? state_reg : state_next;
    rom_op      = (state_reg == ST_FETCH1 && !resume) ? opcode_t'(opcode) : op_reg;
  end

  asap_microcode_rom u_rom (
    .state     (issue_state),
    .op        (rom_op),
    .carry     (carry_flag),
    .zero      (zero_flag),
    .cw        (rom_cw),
    .last_step (rom_last)
  );

  // State, latched opcode and registered control word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_NOP;
      cw_reg     <= CW_NONE;
      last_reg   <= 1'b0;
      frozen_reg <= 1'b0;
      halted_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else if (!enable) begin
      frozen_reg <= 1'b1;
      cw_reg     <= CW_NONE;
      halted_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      frozen_reg <= 1'b0;
      state_reg  <= issue_state;
      if (state_reg == ST_FETCH1 && !resume) begin
        op_reg <= opcode_t'(opcode);
      end
      cw_reg     <= rom_cw;
      last_reg   <= rom_last;
      done_reg   <= rom_last;
      halted_reg <= (issue_state == ST_HALT);
    end
  end

  assign pc_oe      = cw_reg.pc_oe;
  assign pc_ie      = cw_reg.pc_ie;
  assign pc_inc     = cw_reg.pc_inc;
  assign mar_ie     = cw_reg.mar_ie;
  assign ram_oe     = cw_reg.ram_oe;
  assign ram_ie     = cw_reg.ram_ie;
  assign ir_ie      = cw_reg.ir_ie;
  assign ir_oe      = cw_reg.ir_oe;
  assign a_ie       = cw_reg.a_ie;
  assign a_oe       = cw_reg.a_oe;
  assign b_ie       = cw_reg.b_ie;
  assign alu_oe     = cw_reg.alu_oe;
  assign alu_sub    = cw_reg.alu_sub;
  assign flags_ie   = cw_reg.flags_ie;
  assign out_ie     = cw_reg.out_ie;
  assign halted     = halted_reg;
  assign instr_done = done_reg;

endmodule

// File: tb/tb_asap_control_sequencer.sv
// Scoreboard bench for the ASAP-1 control sequencer. The stimulus side pushes
// the expected 17-bit output word for each clock; the monitor pops one entry
// per negedge and also checks the bus-drive invariant every cycle.
module tb_asap_control_sequencer;

  logic       clk = 1'b0;
  logic       rst, enable, carry_flag, zero_flag;
  logic [3:0] opcode;
  logic pc_oe, pc_ie, pc_inc, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe;
  logic a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie, halted, instr_done;

  always #5 clk = ~clk;

  asap_control_sequencer #(.OPW(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_oe(pc_oe), .pc_ie(pc_ie), .pc_inc(pc_inc), .mar_ie(mar_ie),
    .ram_oe(ram_oe), .ram_ie(ram_ie), .ir_ie(ir_ie), .ir_oe(ir_oe),
    .a_ie(a_ie), .a_oe(a_oe), .b_ie(b_ie), .alu_oe(alu_oe), .alu_sub(alu_sub),
    .flags_ie(flags_ie), .out_ie(out_ie), .halted(halted), .instr_done(instr_done)
  );

  localparam logic [16:0] PC_OE    = 17'h00001;
  localparam logic [16:0] PC_IE    = 17'h00002;
  localparam logic [16:0] PC_INC   = 17'h00004;
  localparam logic [16:0] MAR_IE   = 17'h00008;
  localparam logic [16:0] RAM_OE   = 17'h00010;
  localparam logic [16:0] RAM_IE   = 17'h00020;
  localparam logic [16:0] IR_IE    = 17'h00040;
  localparam logic [16:0] IR_OE    = 17'h00080;
  localparam logic [16:0] A_IE     = 17'h00100;
  localparam logic [16:0] A_OE     = 17'h00200;
  localparam logic [16:0] B_IE     = 17'h00400;
  localparam logic [16:0] ALU_OE   = 17'h00800;
  localparam logic [16:0] ALU_SUB  = 17'h01000;
  localparam logic [16:0] FLAGS_IE = 17'h02000;
  localparam logic [16:0] OUT_IE   = 17'h04000;
  localparam logic [16:0] HALTED   = 17'h08000;
  localparam logic [16:0] DONE     = 17'h10000;

  logic [16:0] act;
  assign act = {instr_done, halted, out_ie, flags_ie, alu_sub, alu_oe, b_ie, a_oe,
                a_ie, ir_oe, ir_ie, ram_ie, ram_oe, mar_ie, pc_inc, pc_ie, pc_oe};

  typedef struct {
    logic [16:0] exp;
    int          id;
  } item_t;

  item_t sb_q[$];
  int    errors = 0;
  int    checks = 0;
  int    instr_id = 0;

  // Monitor: one expected word per clock, plus the bus-drive invariant.
  always @(negedge clk) begin
    item_t it;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL word instr=%0d got=%05h want=%05h", it.id, act, it.exp);
      end
    end
    checks++;
    if ($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) > 1 || (ram_ie && ram_oe)) begin
      errors++;
      $display("FAIL bus_invariant got oe=%05b ram_ie=%0b want at most one oe, no ram_ie with ram_oe",
               {pc_oe, ram_oe, ir_oe, a_oe, alu_oe}, ram_ie);
    end
  end

  task automatic tick(input logic [16:0] e);
    item_t it;
    it.exp = e;
    it.id  = instr_id;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op, input logic c, input logic z);
    instr_id++;
    opcode     = op;
    carry_flag = c;
    zero_flag  = z;
    $display("instr %0d op=%h carry=%0b zero=%0b", instr_id, op, c, z);
    tick(PC_OE | MAR_IE);
    tick(RAM_OE | IR_IE | PC_INC);
  endtask

  // Full instruction with hand-written execute words per opcode.
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
    fetch(op, c, z);
    case (op)
      4'h1: begin tick(IR_OE | MAR_IE); tick(RAM_OE | A_IE | DONE); end
      4'h2: begin tick(IR_OE | MAR_IE); tick(RAM_OE | B_IE); tick(ALU_OE | A_IE | FLAGS_IE | DONE); end
      4'h3: begin tick(IR_OE | MAR_IE); tick(RAM_OE | B_IE); tick(ALU_OE | A_IE | FLAGS_IE | ALU_SUB | DONE); end
      4'h4: begin tick(IR_OE | MAR_IE); tick(A_OE | RAM_IE | DONE); end
      4'h5: tick(IR_OE | A_IE | DONE);
      4'h6: tick(IR_OE | PC_IE | DONE);
      4'h7: tick(c ? (IR_OE | PC_IE | DONE) : (IR_OE | DONE));
      4'h8: tick(z ? (IR_OE | PC_IE | DONE) : (IR_OE | DONE));
      4'hE: tick(A_OE | OUT_IE | DONE);
      default: tick(DONE);  // NOP, HLT, 9-D
    endcase
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(17'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    opcode     = 4'h0;
    carry_flag = 1'b0;
    zero_flag  = 1'b0;
    tick(17'h0);
    tick(17'h0);
    rst    = 1'b0;
    enable = 1'b1;

    // Basic sequences from IDLE.
    run_instr(4'h5, 1'b0, 1'b0);  // LDI
    run_instr(4'h3, 1'b0, 1'b0);  // SUB
    run_instr(4'h2, 1'b1, 1'b1);  // ADD
    run_instr(4'h7, 1'b0, 1'b0);  // JC not taken
    run_instr(4'h7, 1'b1, 1'b0);  // JC taken
    run_instr(4'h8, 1'b1, 1'b0);  // JZ not taken
    run_instr(4'h8, 1'b0, 1'b1);  // JZ taken
    run_instr(4'h1, 1'b0, 1'b0);  // LDA
    run_instr(4'h4, 1'b0, 1'b0);  // STA
    run_instr(4'h6, 1'b0, 1'b0);  // JMP
    run_instr(4'hE, 1'b0, 1'b0);  // OUT
    run_instr(4'h0, 1'b0, 1'b0);  // NOP
    run_instr(4'hB, 1'b0, 1'b0);  // undefined

    // ADD with a three-cycle freeze in EXEC1.
    fetch(4'h2, 1'b0, 1'b0);
    tick(IR_OE | MAR_IE);
    tick(RAM_OE | B_IE);
    enable = 1'b0;
    repeat (3) tick(17'h0);
    enable = 1'b1;
    tick(RAM_OE | B_IE);
    tick(ALU_OE | A_IE | FLAGS_IE | DONE);
    run_instr(4'h5, 1'b0, 1'b0);

    // HLT: halted persists until reset, then the sequencer restarts from IDLE.
    run_instr(4'hF, 1'b0, 1'b0);
    repeat (20) tick(HALTED);
    pulse_reset();
    run_instr(4'h5, 1'b0, 1'b0);

    // Randomised opcode stream with occasional reset mid-EXEC1.
    for (int n = 0; n < 2400; n++) begin
      if (n % 50 == 25) begin
        fetch(4'h2, 1'b0, 1'b0);
        tick(IR_OE | MAR_IE);
        tick(RAM_OE | B_IE);
        pulse_reset();
      end else begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (op == 4'hF) begin
          repeat (2) tick(HALTED);
          pulse_reset();
        end
      end
    end

    // Let the monitor drain the last entry.
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
